bcd_down_timer: RTL and testbench

- Parametrised multi-digit BCD down-counting timer for the irrigation timer path.
- Generalises the single-digit 9→0 counter to DIGITS cascaded digits with borrow chaining. Each digit can be configured as mod-10 (9..0) or mod-6 (5..0), which gives mm:ss countdowns.
- Adds run/pause control, preset load with clamping, a one-shot expiry pulse and optional auto-repeat.
- Sits between the 1 Hz tick generator and the valve sequencer/display driver.

---
 rtl/bcd_down_timer.sv | 137 +++++++++++++
 tb/tb_bcd_down_timer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counting timer with per-digit mod-10/mod-6 wrap,
// run/pause control, clamped preset load, one-shot expiry and auto-repeat.

module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] cur,
    input  logic       borrow_in,
    input  logic [3:0] load_nib,
    output logic [3:0] nxt,
    output logic       borrow_out,
    output logic [3:0] clamped
);
    always_comb begin
        nxt        = cur;
        borrow_out = 1'b0;
        clamped    = (load_nib > MAX) ? MAX : load_nib;
        if (borrow_in) begin
            if (cur == 4'd0) begin
                nxt        = MAX;
                borrow_out = 1'b1;
            end else begin
                nxt = cur - 4'd1;
            end
        end
    end
endmodule

module bcd_down_timer #(
    parameter int                DIGITS    = 4,
    parameter logic [DIGITS-1:0] MOD6_MASK = 4'b0100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  repeat_en,
    output logic [4*DIGITS-1:0]   q_bus,
    output logic                  running,
    output logic                  done,
    output logic                  zero
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t                       state_q, state_d;
    logic [DIGITS-1:0][3:0]       q_r, q_d;
    logic [DIGITS-1:0][3:0]       preset_r, preset_d;
    logic [DIGITS-1:0][3:0]       dec_val, clamp_val, load_nibs;
    logic [DIGITS:0]              borrow;
    logic                         done_d;
    // Set on a repeat expiry: the next tick reloads the preset instead of counting.
    logic                         hold_q, hold_d;

    assign load_nibs = load_value;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        localparam logic [3:0] MAXI = MOD6_MASK[i] ? 4'd5 : 4'd9;
        bcd_digit #(.MAX(MAXI)) u_dig (
            .cur        (q_r[i]),
            .borrow_in  (borrow[i]),
            .load_nib   (load_nibs[i]),
            .nxt        (dec_val[i]),
            .borrow_out (borrow[i+1]),
            .clamped    (clamp_val[i])
        );
    end

    assign q_bus   = q_r;
    assign zero    = (q_r == '0);
    assign running = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        q_d      = q_r;
        preset_d = preset_r;
        done_d   = 1'b0;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    q_d      = clamp_val;
                    preset_d = clamp_val;
                end else if (start && !zero) begin
                    state_d = RUN;
                end
            end
            PAUSED: begin
                if (load) begin
                    q_d      = clamp_val;
                    preset_d = clamp_val;
                    state_d  = IDLE;
                end else if (start && !stop && !zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSED;
                    hold_d  = 1'b0;
                end else if (tick) begin
                    if (hold_q) begin
                        q_d    = preset_r;
                        hold_d = 1'b0;
                    end else begin
                        q_d = dec_val;
                        if (dec_val == '0) begin
                            done_d = 1'b1;
                            if (repeat_en) hold_d  = 1'b1;
                            else           state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            q_r      <= '0;
            preset_r <= '0;
            done     <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_r      <= q_d;
            preset_r <= preset_d;
            done     <= done_d;
            hold_q   <= hold_d;
        end
    end
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer (DIGITS=4, default mask 4'b0100).

module tb_bcd_down_timer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, repeat_en = 1'b0;
    logic [15:0] load_value = '0;
    logic [15:0] q_bus;
    logic        running, done, zero;
    int          n_tests = 0, n_fail = 0;

    bcd_down_timer #(.DIGITS(4), .MOD6_MASK(4'b0100)) dut (
        .clock(clock), .reset(reset), .tick(tick), .load(load),
        .load_value(load_value), .start(start), .stop(stop),
        .repeat_en(repeat_en), .q_bus(q_bus), .running(running),
        .done(done), .zero(zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; cyc(); reset = 1'b1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_value = v; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        chk("rst_q", q_bus, 16'h0000);
        chk("rst_run", running, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", zero, 1);
        reset = 1'b1;

        // borrow across digits, mod-6 wrap
        do_load(16'h0100);
        chk("ld0100", q_bus, 16'h0100);
        do_start();
        chk("run0100", running, 1);
        do_tick(); chk("t0099", q_bus, 16'h0099);
        do_tick(); chk("t0098", q_bus, 16'h0098);
        do_load(16'h0000); chk("ld_in_run", q_bus, 16'h0098);
        do_stop(); chk("stop_run", running, 0);
        do_load(16'h1000); chk("ld1000", q_bus, 16'h1000);
        do_start(); do_tick();
        chk("mod6_wrap", q_bus, 16'h0599);
        chk("mod6_done", done, 0);

        // expiry without repeat
        do_reset();
        do_load(16'h0003); do_start();
        do_tick(); chk("e2", q_bus, 16'h0002);
        do_tick(); chk("e1", q_bus, 16'h0001);
        do_tick(); chk("e0", q_bus, 16'h0000);
        chk("e_done", done, 1);
        chk("e_run", running, 0);
        chk("e_zero", zero, 1);
        cyc(); chk("e_done_1shot", done, 0);
        do_tick(); chk("e_tick_idle", q_bus, 16'h0000);
        do_start(); chk("e_start_zero", running, 0);

        // auto-repeat
        do_load(16'h0002); repeat_en = 1'b1; do_start();
        do_tick(); chk("r1", q_bus, 16'h0001);
        do_tick(); chk("r0", q_bus, 16'h0000);
        chk("r_done", done, 1);
        chk("r_run", running, 1);
        cyc(); chk("r_done_1shot", done, 0);
        do_tick(); chk("r_reload", q_bus, 16'h0002);
        chk("r_run2", running, 1);
        chk("r_done2", done, 0);
        repeat_en = 1'b0;
        do_stop(); chk("r_stop_done", done, 0);

        // pause / resume, stop beats tick
        do_load(16'h0010); do_start();
        do_tick(); chk("p9", q_bus, 16'h0009);
        tick = 1'b1; stop = 1'b1; cyc(); tick = 1'b0; stop = 1'b0;
        chk("p_hold", q_bus, 16'h0009);
        chk("p_paused", running, 0);
        do_tick(); chk("p_ign_tick", q_bus, 16'h0009);
        do_start(); chk("p_resume", running, 1);
        do_tick(); chk("p8", q_bus, 16'h0008);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("p_stop_wins", running, 0);

        // clamp, start with zero
        do_load(16'hFFFF); chk("clamp", q_bus, 16'h9599);
        do_load(16'h0000); do_start(); chk("start_zero", running, 0);

        // load and start together in IDLE: load only
        load = 1'b1; start = 1'b1; load_value = 16'h0007; cyc(); load = 1'b0; start = 1'b0;
        chk("ldst_q", q_bus, 16'h0007);
        chk("ldst_run", running, 0);

        // mid-count reset
        do_load(16'h0046); do_start(); do_tick();
        chk("mr_pre", q_bus, 16'h0045);
        do_reset();
        chk("mr_q", q_bus, 16'h0000);
        chk("mr_run", running, 0);
        chk("mr_done", done, 0);
        do_start(); chk("mr_start", running, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
